// File: rtl/uart_seg_pkg.sv
// Shared constants, types and seven-segment decode for the UART-driven
// scrolling display.
package uart_seg_pkg;

  localparam logic [7:0] CHR_0      = 8'h30;
  localparam logic [7:0] CHR_9      = 8'h39;
  localparam logic [7:0] CMD_START  = 8'h53;
  localparam logic [7:0] CMD_STOP   = 8'h50;
  localparam logic [7:0] CMD_CLEAR  = 8'h43;
  localparam logic [7:0] CMD_RATE_A = 8'h61;
  localparam logic [7:0] CMD_RATE_D = 8'h64;

  localparam logic [7:0] ACK_CMD    = 8'h4B;
  localparam logic [7:0] ACK_DROP   = 8'h58;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef logic [1:0] rate_t;

  // Active-high gfedcba pattern; any non-decimal code renders blank.
  function automatic logic [6:0] dec_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_digit_fifo.sv
// Synchronous 4-bit digit FIFO with flush; a push while full is only
// taken when a pop frees an entry in the same cycle.
import uart_seg_pkg::*;

module seg_digit_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [3:0]    din,
  input  logic          pop,
  output logic [3:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_seg_scroll_ctrl.sv
// Decodes UART bytes into digits/commands, buffers digits and scrolls them
// across the seven-segment digits, acknowledging each accepted byte.
import uart_seg_pkg::*;

module uart_seg_scroll_ctrl #(
  parameter  int NUM_DIGITS     = 3,
  parameter  int FIFO_DEPTH     = 16,
  parameter  int BASE_DIV       = 50000000,
  parameter  int SEG_ACTIVE_LOW = 1,
  localparam int CW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [CW-1:0]           fifo_count,
  output logic                    overflow,
  output logic                    scrolling
);

  localparam int         CNT_W   = $clog2(BASE_DIV + 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_e                  state_q, state_d;
  rate_t                   rate_q, rate_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              disp_q [NUM_DIGITS];
  logic [3:0]              disp_d [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    scrolling_q, scrolling_d;

  logic        is_digit, is_start, is_stop, is_clear, is_rate, is_cmd;
  logic        tick, fifo_pop, push_ok;
  logic [31:0] period;
  logic [7:0]  ack_byte;
  logic [6:0]  seg_pat;
  logic [3:0]  fifo_head;
  logic        fifo_full, fifo_empty;

  seg_digit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (is_clear),
    .push  (is_digit),
    .din   (rx_data[3:0]),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    is_digit = rx_valid && (rx_data >= CHR_0) && (rx_data <= CHR_9);
    is_start = rx_valid && (rx_data == CMD_START);
    is_stop  = rx_valid && (rx_data == CMD_STOP);
    is_clear = rx_valid && (rx_data == CMD_CLEAR);
    is_rate  = rx_valid && (rx_data >= CMD_RATE_A) && (rx_data <= CMD_RATE_D);
    is_cmd   = is_start || is_stop || is_clear || is_rate;

    period   = 32'(BASE_DIV) >> rate_q;
    tick     = (state_q == RUN) && (cnt_q == CNT_W'(period - 32'd1));
    // A clear in the tick cycle must not consume a FIFO entry.
    fifo_pop = tick && !fifo_empty && !is_clear;
    push_ok  = is_digit && (!fifo_full || fifo_pop);

    state_d = state_q;
    if (is_clear)                        state_d = IDLE;
    else if (is_start && state_q == IDLE) state_d = RUN;
    else if (is_stop && state_q == RUN)   state_d = IDLE;
    scrolling_d = (state_d == RUN);

    rate_d = rate_q;
    if (is_rate) rate_d = rate_t'(rx_data[2:0] - 3'd1);

    // Held at zero outside RUN so entering RUN always starts a full period.
    cnt_d = cnt_q + CNT_W'(1);
    if (state_q != RUN || tick || is_rate) cnt_d = '0;

    disp_d = disp_q;
    if (is_clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp_d[k] = BLANK_CODE;
    end else if (tick) begin
      for (int k = 1; k < NUM_DIGITS; k++) disp_d[k] = disp_q[k-1];
      disp_d[0] = fifo_empty ? BLANK_CODE : fifo_head;
    end

    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_pat = dec_to_seg(disp_q[k]);
      seg_d[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
    end

    overflow_d = overflow_q;
    if (is_clear)                  overflow_d = 1'b0;
    else if (is_digit && !push_ok) overflow_d = 1'b1;

    ack_byte   = !is_digit ? ACK_CMD : (push_ok ? rx_data : ACK_DROP);
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_data_d  = tx_data_q;
    if ((is_digit || is_cmd) && (!tx_valid_q || tx_ready)) begin
      tx_valid_d = 1'b1;
      tx_data_d  = ack_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rate_q      <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= BLANK_CODE;
      seg_q       <= {NUM_DIGITS{SEG_OFF}};
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      scrolling_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      overflow_q  <= overflow_d;
      scrolling_q <= scrolling_d;
    end
  end

  assign seg       = seg_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign overflow  = overflow_q;
  assign scrolling = scrolling_q;

endmodule

// File: tb/tb_uart_seg_scroll_ctrl.sv
// Directed bench for uart_seg_scroll_ctrl: BASE_DIV=8, 3 digits, 4-deep FIFO,
// active-low segments.
module tb_uart_seg_scroll_ctrl;

  localparam int BL = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [20:0] seg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        scrolling;

  int vectors = 0;
  int errors  = 0;

  uart_seg_scroll_ctrl #(
    .NUM_DIGITS     (3),
    .FIFO_DEPTH     (4),
    .BASE_DIV       (8),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .seg        (seg),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .scrolling  (scrolling)
  );

  always #5 clk = ~clk;

  // Active-low gfedcba codes worked out by hand from the standard patterns.
  function automatic logic [6:0] segc(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] exp_seg(input int d2, input int d1, input int d0);
    return {segc(d2), segc(d1), segc(d0)};
  endfunction

  // Called at a negedge; the byte is sampled at the next posedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (scrolling !== 1'b0) begin errors++; $display("FAIL rst_scrolling got %b want 0", scrolling); end
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    vectors++; if (seg !== 21'h1FFFFF) begin errors++; $display("FAIL rst_seg got %h want 1fffff", seg); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    send(8'h41);
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ign_tx_valid got %b want 0", tx_valid); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ign_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_scroll();
    do_reset();
    send(8'h31);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin errors++; $display("FAIL ack_1 got %b/%h want 1/31", tx_valid, tx_data); end
    send(8'h32);
    vectors++; if (tx_data !== 8'h32) begin errors++; $display("FAIL ack_2 got %h want 32", tx_data); end
    send(8'h33);
    vectors++; if (tx_data !== 8'h33) begin errors++; $display("FAIL ack_3 got %h want 33", tx_data); end
    send(8'h53);
    vectors++; if (tx_data !== 8'h4B) begin errors++; $display("FAIL ack_S got %h want 4b", tx_data); end
    vectors++; if (scrolling !== 1'b1) begin errors++; $display("FAIL run_scrolling got %b want 1", scrolling); end
    repeat (8) @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, BL)) begin errors++; $display("FAIL pre_tick1 seg got %h want %h", seg, exp_seg(BL, BL, BL)); end
    @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, 1)) begin errors++; $display("FAIL tick1 seg got %h want %h", seg, exp_seg(BL, BL, 1)); end
    vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL tick1_count got %0d want 2", fifo_count); end
    repeat (8) @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, 1, 2)) begin errors++; $display("FAIL tick2 seg got %h want %h", seg, exp_seg(BL, 1, 2)); end
    repeat (8) @(negedge clk);
    vectors++; if (seg !== exp_seg(1, 2, 3)) begin errors++; $display("FAIL tick3 seg got %h want %h", seg, exp_seg(1, 2, 3)); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL tick3_count got %0d want 0", fifo_count); end
    repeat (8) @(negedge clk);
    vectors++; if (seg !== exp_seg(2, 3, BL)) begin errors++; $display("FAIL tick4 seg got %h want %h", seg, exp_seg(2, 3, BL)); end
  endtask

  task automatic test_overflow();
    send(8'h50);
    vectors++; if (scrolling !== 1'b0) begin errors++; $display("FAIL stop_scrolling got %b want 0", scrolling); end
    repeat (10) @(negedge clk);
    vectors++; if (seg !== exp_seg(2, 3, BL)) begin errors++; $display("FAIL idle_hold seg got %h want %h", seg, exp_seg(2, 3, BL)); end
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i));
    vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL pre_ovf got %b want 0", overflow); end
    send(8'h35);
    vectors++; if (tx_data !== 8'h58) begin errors++; $display("FAIL drop_ack got %h want 58", tx_data); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    send(8'h43);
    vectors++; if (tx_data !== 8'h4B) begin errors++; $display("FAIL clr_ack got %h want 4b", tx_data); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", overflow); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d want 0", fifo_count); end
    @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, BL)) begin errors++; $display("FAIL clr_seg got %h want %h", seg, exp_seg(BL, BL, BL)); end
  endtask

  task automatic test_rate();
    do_reset();
    for (int i = 4; i <= 7; i++) send(8'h30 + 8'(i));
    send(8'h53);
    send(8'h63);
    vectors++; if (tx_data !== 8'h4B) begin errors++; $display("FAIL rate_ack got %h want 4b", tx_data); end
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL rate_c_e2 got %0d want 4", fifo_count); end
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rate_c_tick1 got %0d want 3", fifo_count); end
    @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, 4)) begin errors++; $display("FAIL rate_c_seg got %h want %h", seg, exp_seg(BL, BL, 4)); end
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rate_c_tick2 got %0d want 2", fifo_count); end
    send(8'h62);
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rate_b_restart got %0d want 2", fifo_count); end
    repeat (2) @(negedge clk);
    vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rate_b_e9 got %0d want 2", fifo_count); end
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rate_b_tick got %0d want 1", fifo_count); end
    repeat (3) @(negedge clk);
    send(8'h43);
    vectors++; if (scrolling !== 1'b0) begin errors++; $display("FAIL clr_tick_scrolling got %b want 0", scrolling); end
    @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, BL)) begin errors++; $display("FAIL clr_tick_seg got %h want %h", seg, exp_seg(BL, BL, BL)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tx_ready = 1'b0;
    send(8'h37);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h37) begin errors++; $display("FAIL bp_first got %b/%h want 1/37", tx_valid, tx_data); end
    send(8'h38);
    vectors++; if (tx_data !== 8'h37) begin errors++; $display("FAIL bp_hold got %h want 37", tx_data); end
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h37) begin errors++; $display("FAIL bp_hold2 got %b/%h want 1/37", tx_valid, tx_data); end
    vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL bp_count got %0d want 2", fifo_count); end
    tx_ready = 1'b1;
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", tx_valid); end
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_no_8 got %b want 0", tx_valid); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i));
    send(8'h53);
    repeat (7) @(negedge clk);
    send(8'h39);
    vectors++; if (tx_data !== 8'h39) begin errors++; $display("FAIL fp_ack got %h want 39", tx_data); end
    vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fp_count got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf got %b want 0", overflow); end
    @(negedge clk);
    vectors++; if (seg !== exp_seg(BL, BL, 1)) begin errors++; $display("FAIL fp_seg got %h want %h", seg, exp_seg(BL, BL, 1)); end
  endtask

  task automatic test_reset_midrun();
    tx_ready = 1'b0;
    send(8'h35);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h58) begin errors++; $display("FAIL mr_pending got %b/%h want 1/58", tx_valid, tx_data); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (scrolling !== 1'b0) begin errors++; $display("FAIL mr_scrolling got %b want 0", scrolling); end
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_tx_valid got %b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mr_tx_data got %h want 00", tx_data); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mr_count got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL mr_ovf got %b want 0", overflow); end
    vectors++; if (seg !== 21'h1FFFFF) begin errors++; $display("FAIL mr_seg got %h want 1fffff", seg); end
    reset = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_scroll();
    test_overflow();
    test_rate();
    test_backpressure();
    test_full_pop();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
